// File: rtl/mac_accumulator.sv
// mac_accumulator: saturating signed dot-product accumulator with valid/ready result handshake
module mac_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_Clear,
  input  logic              in_Valid,
  output logic              in_Ready,
  input  logic [PROD_W-1:0] in_Z,
  input  logic              in_Last,
  output logic              out_Valid,
  input  logic              out_Ready,
  output logic [ACC_W-1:0]  out_Acc,
  output logic [CNT_W-1:0]  out_Count,
  output logic              out_Overflow
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  logic [1:0]       state;
  logic [ACC_W-1:0] ext;
  logic [ACC_W:0]   sum;
  logic             sat_hit;
  logic [ACC_W-1:0] nxt;
  logic             beat;
  assign ext       = ACC_W'($signed(in_Z));
  assign sum       = {out_Acc[ACC_W-1], out_Acc} + {ext[ACC_W-1], ext};
  // the extra top bit disagreeing with the accumulator sign bit means the true sum left the range
  assign sat_hit   = sum[ACC_W] ^ sum[ACC_W-1];
  assign nxt       = sat_hit ? (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                             : sum[ACC_W-1:0];
  assign in_Ready  = state != DONE;
  assign out_Valid = state == DONE;
  assign beat      = in_Valid && in_Ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      out_Acc      <= '0;
      out_Count    <= '0;
      out_Overflow <= 1'b0;
    end else if (in_Clear) begin
      state        <= IDLE;
      out_Acc      <= '0;
      out_Count    <= '0;
      out_Overflow <= 1'b0;
    end else if (state == DONE) begin
      if (out_Ready) state <= IDLE;
    end else if (beat) begin
      state        <= in_Last ? DONE : ACCUM;
      out_Acc      <= (state == IDLE) ? ext : nxt;
      out_Count    <= (state == IDLE) ? CNT_W'(1) : ((&out_Count) ? out_Count : out_Count + 1'b1);
      out_Overflow <= (state == IDLE) ? 1'b0 : (out_Overflow | sat_hit);
    end
  end
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed checks of the 72-bit accumulator plus a 64-bit instance for saturation
module tb_mac_accumulator;
  logic clk = 0, rst_n = 0, clr = 0, vld = 0, last = 0, ordy = 1;
  logic signed [63:0] z = 0;
  logic        d_irdy, d_ovld, d_ovf, s_irdy, s_ovld, s_ovf;
  logic [71:0] d_acc;
  logic [63:0] s_acc;
  logic [15:0] d_cnt, s_cnt;
  int pass = 0, total = 0;

  always #5 clk = ~clk;

  mac_accumulator d (.clk(clk), .rst_n(rst_n), .in_Clear(clr), .in_Valid(vld), .in_Ready(d_irdy),
    .in_Z(z), .in_Last(last), .out_Valid(d_ovld), .out_Ready(ordy), .out_Acc(d_acc),
    .out_Count(d_cnt), .out_Overflow(d_ovf));
  mac_accumulator #(.ACC_W(64)) s (.clk(clk), .rst_n(rst_n), .in_Clear(clr), .in_Valid(vld),
    .in_Ready(s_irdy), .in_Z(z), .in_Last(last), .out_Valid(s_ovld), .out_Ready(ordy),
    .out_Acc(s_acc), .out_Count(s_cnt), .out_Overflow(s_ovf));

  task automatic send(input logic signed [63:0] v, input logic l);
    vld = 1; z = v; last = l;
    @(posedge clk); #1;
    vld = 0; last = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; #3;
    total++; if (d_ovld !== 0) $display("FAIL reset_valid got %b exp 0", d_ovld); else pass++;
    total++; if (d_acc !== 72'd0) $display("FAIL reset_acc got %h exp 0", d_acc); else pass++;
    total++; if (d_cnt !== 16'd0) $display("FAIL reset_count got %0d exp 0", d_cnt); else pass++;
    total++; if (d_ovf !== 0) $display("FAIL reset_ovf got %b exp 0", d_ovf); else pass++;
    @(negedge clk); rst_n = 1; tick();
    total++; if (d_irdy !== 1) $display("FAIL reset_ready got %b exp 1", d_irdy); else pass++;
  endtask

  task automatic test_basic();
    ordy = 1;
    send(-100, 0); send(45, 0);
    total++; if (d_ovld !== 0) $display("FAIL basic_early_valid got %b exp 0", d_ovld); else pass++;
    send(91, 1);
    total++; if (d_ovld !== 1) $display("FAIL basic_valid got %b exp 1", d_ovld); else pass++;
    total++; if (d_acc !== 72'sd36) $display("FAIL basic_acc got %h exp %h", d_acc, 72'sd36); else pass++;
    total++; if (d_cnt !== 16'd3) $display("FAIL basic_count got %0d exp 3", d_cnt); else pass++;
    total++; if (d_ovf !== 0) $display("FAIL basic_ovf got %b exp 0", d_ovf); else pass++;
    tick();
    total++; if (d_ovld !== 0) $display("FAIL basic_valid_drop got %b exp 0", d_ovld); else pass++;
    total++; if (d_acc !== 72'sd36) $display("FAIL basic_acc_hold got %h exp %h", d_acc, 72'sd36); else pass++;
  endtask

  task automatic test_single();
    send(-7006652, 1);
    total++; if (d_acc !== -72'sd7006652) $display("FAIL single_acc got %h exp %h", d_acc, -72'sd7006652); else pass++;
    total++; if (d_cnt !== 16'd1) $display("FAIL single_count got %0d exp 1", d_cnt); else pass++;
    total++; if (d_ovld !== 1) $display("FAIL single_valid got %b exp 1", d_ovld); else pass++;
    tick();
  endtask

  task automatic test_backpressure();
    ordy = 0;
    send(-1, 1);
    for (int i = 0; i < 5; i++) begin
      total++; if (d_ovld !== 1 || d_irdy !== 0) $display("FAIL bp_hs_%0d got v=%b r=%b exp v=1 r=0", i, d_ovld, d_irdy); else pass++;
      total++; if (d_acc !== -72'sd1) $display("FAIL bp_acc_%0d got %h exp %h", i, d_acc, -72'sd1); else pass++;
      tick();
    end
    ordy = 1; tick();
    total++; if (d_ovld !== 0) $display("FAIL bp_valid_drop got %b exp 0", d_ovld); else pass++;
    send(4, 1);
    total++; if (d_acc !== 72'sd4 || d_cnt !== 16'd1) $display("FAIL bp_fresh got acc=%h cnt=%0d exp 4/1", d_acc, d_cnt); else pass++;
    tick();
  endtask

  task automatic test_saturation();
    send(64'sh4000_0000_0000_0000, 0); send(64'sh4000_0000_0000_0000, 0); send(-5, 1);
    total++; if (s_acc !== 64'h7FFF_FFFF_FFFF_FFFA) $display("FAIL sat_pos_acc got %h exp 7ffffffffffffffa", s_acc); else pass++;
    total++; if (s_ovf !== 1) $display("FAIL sat_pos_ovf got %b exp 1", s_ovf); else pass++;
    total++; if (d_acc !== 72'h00_7FFF_FFFF_FFFF_FFFB || d_ovf !== 0) $display("FAIL wide_pos got %h ovf=%b exp 007ffffffffffffffb ovf=0", d_acc, d_ovf); else pass++;
    tick();
    send(64'sh8000_0000_0000_0000, 0); send(-1, 1);
    total++; if (s_acc !== 64'h8000_0000_0000_0000) $display("FAIL sat_neg_acc got %h exp 8000000000000000", s_acc); else pass++;
    total++; if (s_ovf !== 1) $display("FAIL sat_neg_ovf got %b exp 1", s_ovf); else pass++;
    total++; if (d_acc !== 72'hFF_7FFF_FFFF_FFFF_FFFF || d_ovf !== 0) $display("FAIL wide_neg got %h ovf=%b exp ff7fffffffffffffff ovf=0", d_acc, d_ovf); else pass++;
    tick();
    send(1, 1);
    total++; if (s_ovf !== 0 || s_acc !== 64'd1) $display("FAIL sat_fresh got acc=%h ovf=%b exp 1/0", s_acc, s_ovf); else pass++;
    tick();
  endtask

  task automatic test_clear();
    send(15, 0); send(3, 0);
    clr = 1; vld = 1; z = 100;
    tick();
    clr = 0; vld = 0;
    total++; if (d_acc !== 72'd0 || d_cnt !== 16'd0 || d_ovld !== 0) $display("FAIL clear got acc=%h cnt=%0d v=%b exp 0/0/0", d_acc, d_cnt, d_ovld); else pass++;
    send(13, 0); send(-7, 1);
    total++; if (d_acc !== 72'sd6 || d_cnt !== 16'd2) $display("FAIL clear_next got acc=%h cnt=%0d exp 6/2", d_acc, d_cnt); else pass++;
    tick();
  endtask

  task automatic test_async_reset();
    send(5, 0); send(6, 0);
    #2 rst_n = 0; #1;
    total++; if (d_acc !== 72'd0 || d_cnt !== 16'd0 || d_ovld !== 0) $display("FAIL areset_mid got acc=%h cnt=%0d v=%b exp 0/0/0", d_acc, d_cnt, d_ovld); else pass++;
    @(negedge clk); rst_n = 1;
    ordy = 0;
    send(7, 1);
    total++; if (d_ovld !== 1) $display("FAIL areset_pre_done got %b exp 1", d_ovld); else pass++;
    #2 rst_n = 0; #1;
    total++; if (d_acc !== 72'd0 || d_ovld !== 0 || d_irdy !== 1) $display("FAIL areset_done got acc=%h v=%b r=%b exp 0/0/1", d_acc, d_ovld, d_irdy); else pass++;
    @(negedge clk); rst_n = 1; ordy = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_saturation();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
